// File: rtl/coin_pkg.sv
// coin_pkg: shared types and constants for the coin sensor front end.
package coin_pkg;

    // Emitter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } emit_state_t;

    // Channel indices into per-channel vectors
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CH_N   = 0;
    localparam int unsigned CH_D   = 1;
    localparam int unsigned CH_Q   = 2;

    // Pending coin counters saturate at PEND_MAX
    localparam int unsigned        PEND_W   = 2;
    localparam logic [PEND_W-1:0]  PEND_MAX = 2'd3;

    // Default debounce configuration
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned CNT_W_DEF           = 4;

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: synchronises, debounces and rising-edge detects one raw coin sensor.
// Ports: clk, reset (async active-low), raw (async sensor), evt_c (one-cycle coin event).
module coin_debounce
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic evt_c
);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_prev;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: level flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    // Level resets high so a sensor held through reset never yields a coin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            level      <= 1'b1;
            level_prev <= 1'b1;
        end else begin
            level_prev <= level;
            if (sync2 != level) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Rising edge of the debounced level only
    assign evt_c = level & ~level_prev;

endmodule

// File: rtl/coin_front_end.sv
// coin_front_end: turns three raw coin sensors into clean, one-cycle, mutually exclusive
// n/d/q pulses for the vending FSM.
// Ports: clk, reset (async active-low), coin_n_raw/coin_d_raw/coin_q_raw (async sensors),
//        clr_ovf (sync clear of ovf), n/d/q (registered coin pulses),
//        busy (coins pending or emitter active), ovf (sticky pending-counter overflow).
module coin_front_end
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic coin_n_raw,
    input  logic coin_d_raw,
    input  logic coin_q_raw,
    input  logic clr_ovf,
    output logic n,
    output logic d,
    output logic q,
    output logic busy,
    output logic ovf
);

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] evt;
    logic [NUM_CH-1:0] grant;
    logic [PEND_W-1:0] pend [NUM_CH];
    logic              any_pend;
    logic              ovf_set;
    emit_state_t       state;
    emit_state_t       state_nxt;

    assign raw_vec = {coin_q_raw, coin_d_raw, coin_n_raw};

    // One conditioning chain per coin channel
    for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
        coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_vec[i]),
            .evt_c(evt[i])
        );
    end

    always_comb begin
        any_pend = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pend[i] != '0) any_pend = 1'b1;
        end
    end

    // Emitter state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Emitter next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_pend) state_nxt = EMIT;
            EMIT:    state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Emitter output decode: fixed priority q > d > n, only from IDLE
    always_comb begin
        grant = '0;
        if (state == IDLE) begin
            if      (pend[CH_Q] != '0) grant[CH_Q] = 1'b1;
            else if (pend[CH_D] != '0) grant[CH_D] = 1'b1;
            else if (pend[CH_N] != '0) grant[CH_N] = 1'b1;
        end
    end

    // Coin pulse registers; grant is zero outside IDLE so pulses last one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n <= 1'b0;
            d <= 1'b0;
            q <= 1'b0;
        end else begin
            n <= grant[CH_N];
            d <= grant[CH_D];
            q <= grant[CH_Q];
        end
    end

    // An event lost to a saturated counter (not offset by a grant) flags overflow
    always_comb begin
        ovf_set = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (evt[i] && !grant[i] && (pend[i] == PEND_MAX)) ovf_set = 1'b1;
        end
    end

    // Saturating pending counters; simultaneous event and grant cancel out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) pend[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (evt[i] && !grant[i]) begin
                    if (pend[i] != PEND_MAX) pend[i] <= pend[i] + PEND_W'(1);
                end else if (!evt[i] && grant[i]) begin
                    pend[i] <= pend[i] - PEND_W'(1);
                end
            end
        end
    end

    // Sticky overflow; set wins over clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
        else if (clr_ovf) ovf <= 1'b0;
    end

    assign busy = any_pend || (state != IDLE);

endmodule

// File: tb/tb_coin_front_end.sv
// tb_coin_front_end: randomized and directed self-checking bench for coin_front_end,
// compared cycle by cycle against a history-based behavioural model.
module tb_coin_front_end;

    localparam int DEB  = 4;
    localparam int HMAX = 4096;

    logic clk        = 1'b0;
    logic reset      = 1'b0;
    logic coin_n_raw = 1'b0;
    logic coin_d_raw = 1'b0;
    logic coin_q_raw = 1'b0;
    logic clr_ovf    = 1'b0;
    logic n, d, q, busy, ovf;

    coin_front_end #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .coin_n_raw(coin_n_raw),
        .coin_d_raw(coin_d_raw),
        .coin_q_raw(coin_q_raw),
        .clr_ovf   (clr_ovf),
        .n         (n),
        .d         (d),
        .q         (q),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: t = edges since reset release
    int       t;
    int       p [3];
    bit       lvl [3];
    int       last_flip [3];
    bit       ev_flag [3];
    bit       m_ovf;
    int       next_free;
    bit [2:0] m_out;
    bit       m_busy;
    bit       raw_hist [3][HMAX];
    logic [4:0] exp_vec;

    // Synchronised sample seen by the debouncer at edge i
    function automatic bit samp(int ch, int i);
        if (i < 2) return 1'b0;
        return raw_hist[ch][i-2];
    endfunction

    task automatic model_reset();
        t = 0; m_ovf = 0; next_free = 0; m_out = '0; m_busy = 0;
        for (int ch = 0; ch < 3; ch++) begin
            p[ch] = 0; lvl[ch] = 1'b1; last_flip[ch] = -100; ev_flag[ch] = 1'b0;
        end
        exp_vec = '0;
    endtask

    task automatic model_step();
        bit r [3];
        int g;
        bit ovf_set;
        r[0] = coin_n_raw; r[1] = coin_d_raw; r[2] = coin_q_raw;
        // emitter: one coin per 3 cycles, quarter first
        g = -1;
        if (t >= next_free)
            for (int ch = 2; ch >= 0; ch--) if (g < 0 && p[ch] > 0) g = ch;
        ovf_set = 0;
        for (int ch = 0; ch < 3; ch++) begin
            bit dec;
            dec = (g == ch);
            if (ev_flag[ch] && !dec) begin
                if (p[ch] == 3) ovf_set = 1; else p[ch]++;
            end else if (!ev_flag[ch] && dec) p[ch]--;
        end
        if (ovf_set) m_ovf = 1; else if (clr_ovf) m_ovf = 0;
        m_out = '0;
        if (g >= 0) begin m_out[g] = 1'b1; next_free = t + 3; end
        // debounce from sample history: DEB differing samples since last flip
        for (int ch = 0; ch < 3; ch++) begin
            bit all_diff;
            if (t < HMAX) raw_hist[ch][t] = r[ch];
            ev_flag[ch] = 1'b0;
            if (t >= DEB - 1 && t - last_flip[ch] >= DEB) begin
                all_diff = 1;
                for (int i = t - DEB + 1; i <= t; i++) if (samp(ch, i) == lvl[ch]) all_diff = 0;
                if (all_diff) begin
                    lvl[ch] = ~lvl[ch];
                    last_flip[ch] = t;
                    ev_flag[ch] = lvl[ch];
                end
            end
        end
        m_busy = (p[0] > 0) || (p[1] > 0) || (p[2] > 0) || (t < next_free - 1);
        exp_vec = {m_out[0], m_out[1], m_out[2], m_busy, m_ovf};
        t++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_raw(input bit [2:0] qdn);
        coin_n_raw = qdn[0]; coin_d_raw = qdn[1]; coin_q_raw = qdn[2];
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic arm();
        set_raw(3'b000);
        repeat (10) begin
            tick();
            checks++;
            if ({n, d, q, busy, ovf} !== exp_vec) begin
                errors++; $display("FAIL arm t=%0d got=%b want=%b", t, {n, d, q, busy, ovf}, exp_vec);
            end
        end
    endtask

    task automatic test_reset();
        set_raw(3'b000);
        #1;
        checks++;
        if ({n, d, q, busy, ovf} !== 5'b0) begin
            errors++; $display("FAIL reset_state got=%b want=00000", {n, d, q, busy, ovf});
        end
        apply_reset();
        arm();
    endtask

    task automatic test_single_nickel();
        int k, e;
        apply_reset(); arm();
        k = t;
        coin_n_raw = 1'b1;
        repeat (16) begin
            tick();
            e = t - 1;
            if (e == k + 13) coin_n_raw = 1'b0;
            checks++;
            if ({n, d, q, busy, ovf} !== exp_vec) begin
                errors++; $display("FAIL single_nickel_model e=%0d got=%b want=%b", e, {n, d, q, busy, ovf}, exp_vec);
            end
            checks++;
            if (n !== (e == k + 7) || d !== 1'b0 || q !== 1'b0) begin
                errors++; $display("FAIL nickel_latency e=%0d got n=%b d=%b q=%b want n=%b", e, n, d, q, (e == k + 7));
            end
            checks++;
            if (busy !== (e >= k + 6 && e <= k + 8)) begin
                errors++; $display("FAIL nickel_busy e=%0d got=%b want=%b", e, busy, (e >= k + 6 && e <= k + 8));
            end
        end
    endtask

    task automatic test_bounce();
        bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int k, cnt, at;
        apply_reset(); arm();
        k = t; cnt = 0; at = -1;
        for (int i = 0; i < 30; i++) begin
            coin_d_raw = (i < 4) ? pat[i] : (i < 16);
            tick();
            if (d === 1'b1) begin cnt++; at = t - 1; end
            checks++;
            if ({n, d, q, busy, ovf} !== exp_vec) begin
                errors++; $display("FAIL bounce_model e=%0d got=%b want=%b", t - 1, {n, d, q, busy, ovf}, exp_vec);
            end
        end
        checks++;
        if (cnt !== 1 || at !== k + 4 + 7) begin
            errors++; $display("FAIL bounce_pulse got count=%0d edge=%0d want count=1 edge=%0d", cnt, at, k + 11);
        end
    endtask

    task automatic test_simultaneous();
        int k, e, qa, da, na;
        apply_reset(); arm();
        k = t; qa = -1; da = -1; na = -1;
        set_raw(3'b111);
        for (int i = 0; i < 24; i++) begin
            tick();
            e = t - 1;
            if (i == 15) set_raw(3'b000);
            if (q === 1'b1) qa = e;
            if (d === 1'b1) da = e;
            if (n === 1'b1) na = e;
            checks++;
            if ({n, d, q, busy, ovf} !== exp_vec || $countones({n, d, q}) > 1) begin
                errors++; $display("FAIL simultaneous_model e=%0d got=%b want=%b", e, {n, d, q, busy, ovf}, exp_vec);
            end
            if (e == k + 15) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++; $display("FAIL simultaneous_idle got busy=%b want 0", busy);
                end
            end
        end
        checks++;
        if (qa !== k + 7 || da !== k + 10 || na !== k + 13) begin
            errors++; $display("FAIL simultaneous_order got q=%0d d=%0d n=%0d want %0d %0d %0d",
                               qa, da, na, k + 7, k + 10, k + 13);
        end
    endtask

    task automatic test_saturation();
        apply_reset(); arm();
        for (int i = 0; i < 320 + 60; i++) begin
            set_raw((i < 320 && (i % 8) < 4) ? 3'b111 : 3'b000);
            tick();
            checks++;
            if ({n, d, q, busy, ovf} !== exp_vec || $countones({n, d, q}) > 1) begin
                errors++; $display("FAIL saturation_model t=%0d got=%b want=%b", t, {n, d, q, busy, ovf}, exp_vec);
            end
        end
        checks++;
        if (ovf !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL saturation_ovf got ovf=%b busy=%b want ovf=1 busy=0", ovf, busy);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0 || exp_vec[0] !== 1'b0) begin
            errors++; $display("FAIL clr_ovf got ovf=%b want 0", ovf);
        end
    endtask

    task automatic test_held_through_reset();
        int cnt;
        coin_q_raw = 1'b1;
        apply_reset();
        cnt = 0;
        for (int i = 0; i < 48; i++) begin
            if (i == 20) coin_q_raw = 1'b0;
            if (i == 26) coin_q_raw = 1'b1;
            if (i == 38) coin_q_raw = 1'b0;
            tick();
            if (q === 1'b1) cnt++;
            checks++;
            if ({n, d, q, busy, ovf} !== exp_vec) begin
                errors++; $display("FAIL held_reset_model t=%0d got=%b want=%b", t, {n, d, q, busy, ovf}, exp_vec);
            end
            if (i == 19) begin
                checks++;
                if (cnt !== 0) begin
                    errors++; $display("FAIL held_reset_no_coin got count=%0d want 0", cnt);
                end
            end
        end
        checks++;
        if (cnt !== 1) begin
            errors++; $display("FAIL held_reset_rearm got count=%0d want 1", cnt);
        end
    endtask

    task automatic test_reset_mid_emission();
        int cnt;
        bit seen;
        apply_reset(); arm();
        seen = 0;
        coin_n_raw = 1'b1;
        tick();
        coin_d_raw = 1'b1;
        for (int i = 0; i < 15 && !seen; i++) begin
            tick();
            if (n === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL reset_mid_timeout got n=%b want 1 within 15 cycles", n);
        end
        set_raw(3'b000);
        reset = 1'b0;
        #1;
        checks++;
        if ({n, d, q, busy, ovf} !== 5'b0) begin
            errors++; $display("FAIL reset_mid_async got=%b want=00000", {n, d, q, busy, ovf});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        cnt = 0;
        repeat (25) begin
            tick();
            cnt += $countones({n, d, q});
            checks++;
            if ({n, d, q, busy, ovf} !== exp_vec) begin
                errors++; $display("FAIL reset_mid_model t=%0d got=%b want=%b", t, {n, d, q, busy, ovf}, exp_vec);
            end
        end
        checks++;
        if (cnt !== 0) begin
            errors++; $display("FAIL reset_mid_discard got pulses=%0d want 0", cnt);
        end
    endtask

    task automatic test_random();
        apply_reset(); arm();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) coin_n_raw = ~coin_n_raw;
            if ($urandom_range(0, 5) == 0) coin_d_raw = ~coin_d_raw;
            if ($urandom_range(0, 5) == 0) coin_q_raw = ~coin_q_raw;
            clr_ovf = ($urandom_range(0, 49) == 0);
            tick();
            checks++;
            if ({n, d, q, busy, ovf} !== exp_vec || $countones({n, d, q}) > 1) begin
                errors++; $display("FAIL random t=%0d got=%b want=%b", t, {n, d, q, busy, ovf}, exp_vec);
            end
        end
        clr_ovf = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_nickel();
        test_bounce();
        test_simultaneous();
        test_saturation();
        test_held_through_reset();
        test_reset_mid_emission();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
